// File: rtl/sap1_prog_loader.sv
// SAP-1 program loader: takes 16 program bytes plus an XOR checksum from
// external pins, writes them to program RAM, and holds the core until verified.
module sap1_prog_loader #(
    parameter int                ADDR_W    = 4,
    parameter int                DATA_W    = 8,
    parameter logic [DATA_W-1:0] CSUM_INIT = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ld_mode_pin,
    input  logic              ld_strobe_pin,
    input  logic [DATA_W-1:0] ld_data,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              cpu_hold,
    output logic              ld_busy,
    output logic              ld_done,
    output logic              ld_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_CHECK,
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [ADDR_W-1:0] LAST = '1;

    state_t            state;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] csum;

    logic mode_s1;
    logic mode_s2;
    logic mode_prev;
    logic strb_s1;
    logic strb_s2;
    logic strb_prev;

    logic mode_s;
    logic mode_rise;
    logic strobe_edge;

    assign mode_s      = mode_s2;
    assign mode_rise   = mode_s2 & ~mode_prev;
    assign strobe_edge = strb_s2 & ~strb_prev;

    // Bring the asynchronous pins into clk and keep one extra stage for edges.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mode_s1   <= 1'b0;
            mode_s2   <= 1'b0;
            mode_prev <= 1'b0;
            strb_s1   <= 1'b0;
            strb_s2   <= 1'b0;
            strb_prev <= 1'b0;
        end else begin
            mode_s1   <= ld_mode_pin;
            mode_s2   <= mode_s1;
            mode_prev <= mode_s2;
            strb_s1   <= ld_strobe_pin;
            strb_s2   <= strb_s1;
            strb_prev <= strb_s2;
        end
    end

    // Load sequencer: RAM writes, running checksum and verification.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            addr      <= '0;
            csum      <= CSUM_INIT;
            ram_we    <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
        end else begin
            ram_we <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (mode_s) begin
                        state <= S_LOAD;
                        addr  <= '0;
                        csum  <= CSUM_INIT;
                    end
                end
                S_LOAD: begin
                    if (!mode_s) begin
                        state <= S_ERR;
                    end else if (strobe_edge) begin
                        ram_we    <= 1'b1;
                        ram_wdata <= ld_data;
                        ram_addr  <= addr;
                        csum      <= csum ^ ld_data;
                        if (addr == LAST) begin
                            state <= S_CHECK;
                        end else begin
                            addr <= addr + 1'b1;
                        end
                    end
                end
                S_CHECK: begin
                    if (!mode_s) begin
                        state <= S_ERR;
                    end else if (strobe_edge) begin
                        state <= (ld_data == csum) ? S_DONE : S_ERR;
                    end
                end
                S_DONE: begin
                    if (!mode_s) begin
                        state <= S_IDLE;
                    end
                end
                S_ERR: begin
                    if (mode_rise) begin
                        state <= S_LOAD;
                        addr  <= '0;
                        csum  <= CSUM_INIT;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign ld_busy  = (state == S_LOAD) || (state == S_CHECK);
    assign ld_done  = (state == S_DONE);
    assign ld_err   = (state == S_ERR);
    assign cpu_hold = ld_busy | ld_done | ld_err;

endmodule

// File: tb/tb_sap1_prog_loader.sv
// Directed-plus-random bench for sap1_prog_loader with a behavioural
// model of the load protocol (byte count, XOR checksum, outcome flags).
module tb_sap1_prog_loader;

    logic       clk;
    logic       rst_n;
    logic       ld_mode_pin;
    logic       ld_strobe_pin;
    logic [7:0] ld_data;
    logic       ram_we;
    logic [3:0] ram_addr;
    logic [7:0] ram_wdata;
    logic       cpu_hold;
    logic       ld_busy;
    logic       ld_done;
    logic       ld_err;

    int checks   = 0;
    int failures = 0;
    int wr_cnt   = 0;

    bit       m_mode = 0;
    bit       m_load = 0;
    bit       m_done = 0;
    bit       m_err  = 0;
    int       m_n    = 0;
    logic [7:0] m_x  = 8'h00;

    sap1_prog_loader dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ld_mode_pin  (ld_mode_pin),
        .ld_strobe_pin(ld_strobe_pin),
        .ld_data      (ld_data),
        .ram_we       (ram_we),
        .ram_addr     (ram_addr),
        .ram_wdata    (ram_wdata),
        .cpu_hold     (cpu_hold),
        .ld_busy      (ld_busy),
        .ld_done      (ld_done),
        .ld_err       (ld_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count every write pulse seen outside reset.
    always @(negedge clk) begin
        if (rst_n && ram_we) wr_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_status(input string tag);
        chk({tag, ".hold"}, cpu_hold, m_load | m_done | m_err);
        chk({tag, ".busy"}, ld_busy, m_load);
        chk({tag, ".done"}, ld_done, m_done);
        chk({tag, ".err"}, ld_err, m_err);
    endtask

    task automatic model_reset();
        m_load = 0;
        m_done = 0;
        m_err  = 0;
        m_n    = 0;
        m_x    = 8'h00;
        m_mode = 0;
    endtask

    task automatic set_mode(input bit v, input string tag);
        ld_mode_pin = v;
        if (v && !m_mode && !m_load && !m_done) begin
            m_load = 1;
            m_err  = 0;
            m_n    = 0;
            m_x    = 8'h00;
        end
        if (!v && m_mode) begin
            if (m_load) begin
                m_load = 0;
                m_err  = 1;
            end else if (m_done) begin
                m_done = 0;
            end
        end
        m_mode = v;
        repeat (3) @(negedge clk);
        chk_status(tag);
    endtask

    task automatic strobe(input logic [7:0] b, input int hold_cyc,
                          input string tag);
        bit       exp_we;
        int       exp_a;
        exp_we = 0;
        exp_a  = 0;
        if (m_load && m_n < 16) begin
            exp_we = 1;
            exp_a  = m_n;
            m_x    = m_x ^ b;
            m_n++;
        end else if (m_load) begin
            m_load = 0;
            if (b == m_x) m_done = 1;
            else m_err = 1;
        end
        ld_data       = b;
        ld_strobe_pin = 1'b1;
        repeat (3) @(negedge clk);
        chk({tag, ".we"}, ram_we, exp_we);
        if (exp_we) begin
            chk({tag, ".addr"}, ram_addr, exp_a);
            chk({tag, ".wdata"}, ram_wdata, b);
        end
        @(negedge clk);
        chk({tag, ".we_off"}, ram_we, 1'b0);
        repeat (hold_cyc - 4) @(negedge clk);
        ld_strobe_pin = 1'b0;
        repeat (3) @(negedge clk);
        chk_status({tag, ".st"});
    endtask

    initial begin
        int         base;
        logic [7:0] b;
        rst_n         = 1'b0;
        ld_mode_pin   = 1'b0;
        ld_strobe_pin = 1'b0;
        ld_data       = 8'h00;

        // Reset with pins toggling.
        repeat (2) begin
            @(negedge clk);
            ld_mode_pin   = ~ld_mode_pin;
            ld_strobe_pin = ~ld_strobe_pin;
            ld_data       = 8'($urandom);
        end
        @(negedge clk);
        ld_mode_pin   = 1'b0;
        ld_strobe_pin = 1'b0;
        @(negedge clk);
        chk("rst.we", ram_we, 1'b0);
        chk("rst.addr", ram_addr, 4'h0);
        chk("rst.wdata", ram_wdata, 8'h00);
        chk_status("rst");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        model_reset();

        // Strobes in IDLE are ignored.
        strobe(8'($urandom), 4, "idle_stb0");
        strobe(8'($urandom), 4, "idle_stb1");
        chk("idle.wr_cnt", wr_cnt, 0);

        // Good load, bytes 0..15, checksum 0.
        set_mode(1, "good.mode_on");
        for (int i = 0; i < 16; i++) strobe(8'(i), 4, "good.byte");
        strobe(8'h00, 4, "good.csum");
        chk("good.wr_cnt", wr_cnt, 16);
        set_mode(0, "good.mode_off");

        // Random good load.
        set_mode(1, "rnd.mode_on");
        for (int i = 0; i < 16; i++) strobe(8'($urandom), 4, "rnd.byte");
        strobe(m_x, 4, "rnd.csum");
        set_mode(0, "rnd.mode_off");

        // Bad checksum, sticky ERR, restart on fresh mode rise.
        set_mode(1, "bad.mode_on");
        for (int i = 0; i < 16; i++) strobe(8'(i), 4, "bad.byte");
        strobe(8'h5A, 4, "bad.csum");
        set_mode(0, "bad.mode_off");
        set_mode(1, "bad.restart");
        strobe(8'($urandom), 4, "bad.first");

        // Abort after 5 bytes with a coincident strobe.
        set_mode(0, "abort.pre");
        set_mode(1, "abort.mode_on");
        base = wr_cnt;
        for (int i = 0; i < 5; i++) strobe(8'(8'hA0 + i), 4, "abort.byte");
        ld_data       = 8'hA5;
        ld_strobe_pin = 1'b1;
        ld_mode_pin   = 1'b0;
        m_mode        = 0;
        m_load        = 0;
        m_err         = 1;
        repeat (3) @(negedge clk);
        chk("abort.we", ram_we, 1'b0);
        chk_status("abort");
        @(negedge clk);
        ld_strobe_pin = 1'b0;
        repeat (3) @(negedge clk);
        chk("abort.wr_cnt", wr_cnt - base, 5);
        strobe(8'($urandom), 4, "err.stb");

        // Held strobe gives one write.
        set_mode(1, "held.mode_on");
        base = wr_cnt;
        strobe(8'($urandom), 20, "held");
        chk("held.wr_cnt", wr_cnt - base, 1);
        for (int i = 0; i < 7; i++) strobe(8'($urandom), 4, "mid.byte");

        // Reset mid-load.
        rst_n       = 1'b0;
        ld_mode_pin = 1'b0;
        @(negedge clk);
        model_reset();
        chk("midrst.we", ram_we, 1'b0);
        chk_status("midrst");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        set_mode(1, "fresh.mode_on");
        for (int i = 0; i < 16; i++) begin
            b = 8'($urandom);
            strobe(b, 4, "fresh.byte");
        end
        strobe(m_x, 4, "fresh.csum");
        set_mode(0, "fresh.mode_off");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
